// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller driving the core's active-low nIRQ
// Optional feature: define IRQ_CTRL_THRESHOLD_EN to add the THRESHOLD register at offset 0x18.
module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        memaddr,
    input  logic               memwrite,
    input  logic               memread,
    input  logic [31:0]        writedata,
    input  logic [3:0]         be,
    output logic [31:0]        readdata,
    output logic               sel,
    output logic               nIRQ
);

    localparam logic [5:0] OFF_STATUS    = 6'h00;
    localparam logic [5:0] OFF_RAW       = 6'h01;
    localparam logic [5:0] OFF_ENABLE    = 6'h02;
    localparam logic [5:0] OFF_CLEAR     = 6'h03;
    localparam logic [5:0] OFF_ACTIVE_ID = 6'h04;
    localparam logic [5:0] OFF_TRIGGER   = 6'h05;
`ifdef IRQ_CTRL_THRESHOLD_EN
    localparam logic [5:0] OFF_THRESHOLD = 6'h06;
`endif

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] trigger;

    logic               hit;
    logic [5:0]         offset;
    logic               wr;
    logic [31:0]        wmask32;
    logic [31:0]        wval32;
    logic [NUM_SRC-1:0] wmask;
    logic [NUM_SRC-1:0] wval;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] status;
    logic [NUM_SRC-1:0] eff_status;
    logic [4:0]         active_idx;
    logic [31:0]        active_id;
    logic [31:0]        rd_value;

`ifdef IRQ_CTRL_THRESHOLD_EN
    logic [5:0]         threshold;
    logic [NUM_SRC-1:0] thr_mask;
`endif

    // Byte address bits [1:0] never select anything; only the word offset matters.
    logic unused_ok;
    assign unused_ok = &{1'b0, memaddr[1:0], wval32};

    assign hit     = (memaddr[31:8] == BASE_ADDR[31:8]);
    assign offset  = memaddr[7:2];
    assign wr      = memwrite & hit;
    assign wmask32 = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wval32  = writedata & wmask32;
    assign wmask   = wmask32[NUM_SRC-1:0];
    assign wval    = wval32[NUM_SRC-1:0];

    // A clear bit only counts when its byte lane is enabled, hence the masked value.
    assign clr = (wr && offset == OFF_CLEAR) ? wval : '0;

    assign edge_det = s & ~s_d;

    // Edge sources: set beats a same-cycle clear. Level sources simply track the input.
    assign pending_next = (trigger & (edge_det | (pending & ~clr))) | (~trigger & s);

    assign status = pending & enable;

`ifdef IRQ_CTRL_THRESHOLD_EN
    // Only sources below the threshold may interrupt; zero masks everything.
    always_comb begin
        thr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            thr_mask[i] = (32'(i) < {26'd0, threshold});
        end
    end
    assign eff_status = status & thr_mask;
`else
    assign eff_status = status;
`endif

    // Lowest-index asserted source wins; scan from the top so index 0 overrides.
    always_comb begin
        active_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff_status[i]) begin
                active_idx = 5'(i);
            end
        end
    end

    assign active_id = {|eff_status, 26'd0, active_idx};

    // Read mux uses current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_value = 32'd0;
        case (offset)
            OFF_STATUS:    rd_value = 32'(status);
            OFF_RAW:       rd_value = 32'(pending);
            OFF_ENABLE:    rd_value = 32'(enable);
            OFF_CLEAR:     rd_value = 32'd0;
            OFF_ACTIVE_ID: rd_value = active_id;
            OFF_TRIGGER:   rd_value = 32'(trigger);
`ifdef IRQ_CTRL_THRESHOLD_EN
            OFF_THRESHOLD: rd_value = {26'd0, threshold};
`endif
            default:       rd_value = 32'd0;
        endcase
    end

    // Synchroniser and edge history; reset flushes any edge in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
            s_d   <= '0;
        end else begin
            sync1 <= irq_src;
            s     <= sync1;
            s_d   <= s;
        end
    end

    // Pending, enable and trigger state plus the software-visible config registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            enable  <= '0;
            trigger <= '0;
        end else begin
            pending <= pending_next;
            if (wr && offset == OFF_ENABLE) begin
                enable <= (enable & ~wmask) | wval;
            end
            if (wr && offset == OFF_TRIGGER) begin
                trigger <= (trigger & ~wmask) | wval;
            end
        end
    end

`ifdef IRQ_CTRL_THRESHOLD_EN
    // Threshold lives entirely in byte lane 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            threshold <= 6'd32;
        end else if (wr && offset == OFF_THRESHOLD && be[0]) begin
            threshold <= writedata[5:0];
        end
    end
`endif

    // Registered bus response and interrupt output, one cycle behind the state they reflect.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
            sel      <= 1'b0;
            nIRQ     <= 1'b1;
        end else begin
            sel      <= memread & hit;
            readdata <= (memread & hit) ? rd_value : 32'd0;
            nIRQ     <= ~(|eff_status);
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;

    localparam logic [31:0] BASE   = 32'hFFFF0000;
    localparam logic [31:0] A_STAT = BASE + 32'h00;
    localparam logic [31:0] A_RAW  = BASE + 32'h04;
    localparam logic [31:0] A_EN   = BASE + 32'h08;
    localparam logic [31:0] A_CLR  = BASE + 32'h0C;
    localparam logic [31:0] A_AID  = BASE + 32'h10;
    localparam logic [31:0] A_TRIG = BASE + 32'h14;
    localparam logic [31:0] A_THR  = BASE + 32'h18;
    localparam logic [31:0] A_UNM  = BASE + 32'h1C;

`ifdef IRQ_CTRL_THRESHOLD_EN
    localparam logic [31:0] THR_RST = 32'd32;
`else
    localparam logic [31:0] THR_RST = 32'd0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [31:0] writedata;
    logic [3:0]  be;
    logic [31:0] readdata;
    logic        sel;
    logic        nIRQ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t rd_q[$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    irq_controller #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .memread   (memread),
        .writedata (writedata),
        .be        (be),
        .readdata  (readdata),
        .sel       (sel),
        .nIRQ      (nIRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        memaddr   = a;
        writedata = d;
        be        = b;
        memwrite  = 1'b1;
        tick(1);
        memwrite  = 1'b0;
        be        = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_exp_t e;
        e.exp  = exp;
        e.name = nm;
        rd_q.push_back(e);
        memaddr = a;
        memread = 1'b1;
        tick(1);
        memread = 1'b0;
    endtask

    // Scoreboard: every sel pulse must match the oldest outstanding load.
    always @(negedge clk) begin
        if (sel) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_sel: sel=1 readdata=0x%08h with no load outstanding", readdata);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                if (readdata !== e.exp) begin
                    errors++;
                    $display("FAIL %s: readdata 0x%08h expected 0x%08h", e.name, readdata, e.exp);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        irq_src   = 8'h00;
        memaddr   = 32'h0;
        memwrite  = 1'b0;
        memread   = 1'b0;
        writedata = 32'h0;
        be        = 4'h0;

        vecs[0]  = '{A_EN,         32'hFFFFFFFF, 4'b0001, A_EN,   32'h000000FF, "en_be0"};
        vecs[1]  = '{A_EN,         32'h12345678, 4'b1111, A_EN,   32'h00000078, "en_full"};
        vecs[2]  = '{A_EN,         32'h0000AA00, 4'b0010, A_EN,   32'h00000078, "en_hi_lane"};
        vecs[3]  = '{A_EN,         32'h000000F0, 4'b0000, A_EN,   32'h00000078, "en_no_lane"};
        vecs[4]  = '{A_TRIG,       32'h000000A5, 4'b0001, A_TRIG, 32'h000000A5, "trig_wr"};
        vecs[5]  = '{A_TRIG,       32'h00000000, 4'b1110, A_TRIG, 32'h000000A5, "trig_lane_off"};
        vecs[6]  = '{A_CLR,        32'h000000FF, 4'b1111, A_CLR,  32'h00000000, "clr_reads0"};
        vecs[7]  = '{A_UNM,        32'hFFFFFFFF, 4'b1111, A_UNM,  32'h00000000, "unmapped"};
        vecs[8]  = '{BASE + 32'hB, 32'h0000000F, 4'b1111, A_EN,   32'h0000000F, "addr_lsb_ignored"};
        vecs[9]  = '{32'hFFFE0008, 32'h000000FF, 4'b1111, A_EN,   32'h0000000F, "miss_window"};
        vecs[10] = '{A_STAT,       32'h000000FF, 4'b1111, A_STAT, 32'h00000000, "status_ro"};
        vecs[11] = '{A_AID,        32'h000000FF, 4'b1111, A_AID,  32'h00000000, "aid_ro"};

        tick(3);
        reset = 1'b0;

        // Reset state
        chk("rst_nirq", {31'd0, nIRQ}, 32'd1);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        bus_read(A_STAT, 32'd0, "rst_status");
        bus_read(A_RAW,  32'd0, "rst_raw");
        bus_read(A_EN,   32'd0, "rst_enable");
        bus_read(A_CLR,  32'd0, "rst_clear");
        bus_read(A_AID,  32'd0, "rst_aid");
        bus_read(A_TRIG, 32'd0, "rst_trigger");
        bus_read(A_THR,  THR_RST, "rst_threshold");
        tick(1);
        chk("rst_sel_idle", {31'd0, sel}, 32'd0);

        // Register access table
        for (int i = 0; i < 12; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wbe);
            bus_read(vecs[i].raddr, vecs[i].exp, vecs[i].name);
        end
        chk("tbl_nirq_idle", {31'd0, nIRQ}, 32'd1);

        // Same-cycle read and write returns the old value
        memaddr   = A_EN;
        writedata = 32'h000000AA;
        be        = 4'hF;
        memwrite  = 1'b1;
        rd_q.push_back('{32'h0000000F, "rw_same_cycle"});
        memread   = 1'b1;
        tick(1);
        memwrite  = 1'b0;
        memread   = 1'b0;
        bus_read(A_EN, 32'h000000AA, "rw_after");

        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // Edge pulse on source 2, latency check
        bus_write(A_TRIG, 32'hFF, 4'hF);
        bus_write(A_EN,   32'h04, 4'hF);
        irq_src = 8'h04;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            if (k == 1) irq_src = 8'h00;
            chk($sformatf("edge_lat_c%0d", k), {31'd0, nIRQ}, (k < 4) ? 32'd1 : 32'd0);
        end
        bus_read(A_AID, 32'h80000002, "aid_src2");
        bus_write(A_CLR, 32'h04, 4'hF);
        chk("clr_nirq_lag", {31'd0, nIRQ}, 32'd0);
        tick(1);
        chk("clr_nirq_high", {31'd0, nIRQ}, 32'd1);
        bus_read(A_RAW, 32'd0, "clr_raw");

        // Level mode: CLEAR is ignored, pending tracks input
        bus_write(A_TRIG, 32'h00, 4'hF);
        bus_write(A_EN,   32'h01, 4'hF);
        irq_src = 8'h01;
        tick(4);
        chk("lvl_nirq_low", {31'd0, nIRQ}, 32'd0);
        bus_write(A_CLR, 32'h01, 4'hF);
        tick(1);
        bus_read(A_RAW, 32'h01, "lvl_raw_after_clr");
        chk("lvl_nirq_after_clr", {31'd0, nIRQ}, 32'd0);
        irq_src = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("lvl_drop_c%0d", k), {31'd0, nIRQ}, (k == 4) ? 32'd1 : 32'd0);
        end

        // Priority among edge sources 3 and 5
        bus_write(A_TRIG, 32'hFF, 4'hF);
        bus_write(A_EN,   32'h28, 4'hF);
        irq_src = 8'h28;
        tick(5);
        irq_src = 8'h00;
        tick(3);
        bus_read(A_AID,  32'h80000003, "prio_aid3");
        bus_read(A_STAT, 32'h00000028, "prio_status");
        bus_write(A_CLR, 32'h08, 4'hF);
        bus_read(A_AID,  32'h80000005, "prio_aid5");
        bus_write(A_CLR, 32'h20, 4'hF);
        tick(1);
        chk("prio_all_clr_nirq", {31'd0, nIRQ}, 32'd1);

        // Edge and CLEAR on bit 1 in the same cycle: set wins
        irq_src = 8'h02;
        tick(2);
        bus_write(A_CLR, 32'h02, 4'hF);
        bus_read(A_RAW, 32'h02, "set_beats_clr");
        irq_src = 8'h00;
        bus_write(A_CLR, 32'h02, 4'b0010);
        bus_read(A_RAW, 32'h02, "clr_lane_off");
        bus_write(A_CLR, 32'h02, 4'b0001);
        bus_read(A_RAW, 32'h00, "clr_lane_on");

        // Threshold register, or its absence
        bus_write(A_EN, 32'h10, 4'hF);
        irq_src = 8'h10;
        tick(1);
        irq_src = 8'h00;
        bus_write(A_THR, 32'h02, 4'h1);
        tick(5);
`ifdef IRQ_CTRL_THRESHOLD_EN
        chk("thr2_nirq", {31'd0, nIRQ}, 32'd1);
        bus_read(A_AID,  32'h00000000, "thr2_aid");
        bus_read(A_STAT, 32'h00000010, "thr2_status");
        bus_write(A_THR, 32'h05, 4'h1);
        tick(1);
        chk("thr5_nirq", {31'd0, nIRQ}, 32'd0);
        bus_read(A_THR, 32'h05, "thr5_read");
        bus_read(A_AID, 32'h80000004, "thr5_aid");
`else
        chk("nothr_nirq", {31'd0, nIRQ}, 32'd0);
        bus_read(A_AID,  32'h80000004, "nothr_aid");
        bus_read(A_STAT, 32'h00000010, "nothr_status");
        bus_read(A_THR,  32'h00000000, "nothr_0x18");
`endif
        bus_write(A_CLR, 32'h10, 4'hF);
        tick(1);
        chk("thr_clr_nirq", {31'd0, nIRQ}, 32'd1);

        // Reset mid-operation dominates a write and flushes a synchroniser edge
        bus_write(A_EN,   32'h40, 4'hF);
        bus_write(A_TRIG, 32'h40, 4'hF);
        irq_src = 8'h40;
        tick(1);
        irq_src   = 8'h00;
        reset     = 1'b1;
        memaddr   = A_EN;
        writedata = 32'hFF;
        be        = 4'hF;
        memwrite  = 1'b1;
        tick(1);
        reset     = 1'b0;
        memwrite  = 1'b0;
        be        = 4'h0;
        chk("midrst_nirq", {31'd0, nIRQ}, 32'd1);
        chk("midrst_sel", {31'd0, sel}, 32'd0);
        tick(4);
        bus_read(A_EN,   32'd0, "midrst_enable");
        bus_read(A_RAW,  32'd0, "midrst_raw");
        bus_read(A_TRIG, 32'd0, "midrst_trigger");
        bus_read(A_THR,  THR_RST, "midrst_threshold");
        chk("midrst_nirq_later", {31'd0, nIRQ}, 32'd1);

        tick(3);
        chk("loads_outstanding", rd_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the CPU data-memory bus (memaddr/memwrite/memread/writedata/be/readdata).
- Directly upstream of the pipelined ARM core: its sole job is to drive the core's active-low nIRQ input.
- Samples external interrupt sources, latches pending state and applies per-source enable and trigger mode.
- Exposes STATUS, ENABLE, CLEAR, TRIGGER and ACTIVE_ID registers to software via loads and stores in its address window.

Parameters:
- NUM_SRC, 8: number of interrupt sources, legal 1..32. Register bits at index >= NUM_SRC read 0 and ignore writes.
- BASE_ADDR, 32'hFFFF0000: base of the 256-byte register window. Block hits when memaddr[31:8] == BASE_ADDR[31:8].

Ports:
- clk  input  1  clock. All state updates on posedge.
- reset  input  1  synchronous, active-high.
- irq_src  input  NUM_SRC  asynchronous external interrupt requests, active-high.
- memaddr  input  32  byte address from the core MEM stage.
- memwrite  input  1  store strobe, valid for one cycle.
- memread  input  1  load strobe, valid for one cycle.
- writedata  input  32  store data.
- be  input  4  byte enables for writedata.
- readdata  output  32  load data, registered.
- sel  output  1  registered hit flag; the bus mux selects readdata when sel=1.
- nIRQ  output  1  interrupt request to the core, active-low, registered.

Behaviour:
- Reset values: readdata=0, sel=0, nIRQ=1, pending=0, enable=0, trigger=0 (all level), synchroniser flops=0, edge-history=0.

Input synchronisation:
- Each irq_src bit passes through a 2-flop synchroniser giving s[i].
- A rising edge is detected as s[i] & ~s_d[i], where s_d is one further register.

Pending update (per bit, every cycle):
- Edge mode (trigger[i]=1): a detected edge sets pending[i]. A CLEAR write with 1 clears it. If set and clear hit the same bit in the same cycle, set wins.
- Level mode (trigger[i]=0): pending[i] <= s[i]. CLEAR has no effect.
- Changing trigger[i] does not modify pending[i] in that cycle.

Register map (word-aligned offsets, memaddr[7:2]):
- 0x00 STATUS, RO: pending & enable.
- 0x04 RAW, RO: pending.
- 0x08 ENABLE, RW.
- 0x0C CLEAR, WO, write-1-to-clear; reads return 0.
- 0x10 ACTIVE_ID, RO: bit31 = any STATUS bit set; bits[4:0] = lowest-index set STATUS bit (index 0 is highest priority); other bits 0. Reading does not clear anything.
- 0x14 TRIGGER, RW: 1 = edge, 0 = level.
- Unmapped offsets read 0; writes to them are ignored.

Writes:
- Take effect at the posedge where memwrite=1 and the address hits.
- Honour be per byte lane: writedata[8k+7:8k] applies only if be[k]=1. For CLEAR, a 1-bit in a disabled lane is not a clear.
- memaddr[1:0] is ignored.

Reads:
- 1-cycle latency: when memread=1 and the address hits at edge N, readdata holds the register value sampled at edge N and sel=1 during cycle N+1.
- Otherwise sel=0 and readdata=0.
- A simultaneous memread and memwrite to the same register returns the pre-write value.

Interrupt output:
- nIRQ <= ~(|STATUS_next), registered: one cycle after pending/enable update.
- Latency from an irq_src rising edge to nIRQ low is 4 cycles: 2 sync, 1 pending, 1 output.

Reset mid-operation:
- reset dominates every write, edge and read in the same cycle.
- The cycle after reset deasserts, all state is at its reset value. An edge present in the synchroniser during reset is discarded.

Optional Feature:
- Macro: IRQ_CTRL_THRESHOLD_EN.
- Defined:
  - Adds a THRESHOLD register at 0x18, RW, 6 bits, reset 32.
  - Only STATUS bits with index < THRESHOLD contribute to nIRQ and ACTIVE_ID. THRESHOLD=0 masks all sources.
  - STATUS and RAW reads are unaffected by THRESHOLD.
- Not defined:
  - Offset 0x18 is unmapped (reads 0, writes ignored).
  - nIRQ and ACTIVE_ID use the full STATUS.

Test Plan:
- Reset, then read all registers -> every read returns 0, nIRQ=1, sel=1 only in the cycle after each load.
- TRIGGER=0xFF, ENABLE=0x04, pulse irq_src[2] for 1 cycle -> nIRQ=0 exactly 4 cycles after the pulse; ACTIVE_ID=0x80000002; write CLEAR=0x04 -> nIRQ=1 one cycle later and RAW=0.
- Level mode, ENABLE=0x01, hold irq_src[0]=1 and write CLEAR=0x01 -> RAW stays 0x01 and nIRQ stays 0; drop irq_src[0] -> nIRQ=1 four cycles later.
- Edge mode, sources 3 and 5 pending, ENABLE=0x28 -> ACTIVE_ID=0x80000003; clear bit 3 -> ACTIVE_ID=0x80000005.
- Same-cycle edge on bit 1 and CLEAR=0x02 -> RAW bit1=1 afterwards. Write ENABLE=0xFFFFFFFF with be=4'b0001 -> ENABLE reads 0x000000FF.
- With IRQ_CTRL_THRESHOLD_EN: THRESHOLD=2, bit 4 pending and enabled -> nIRQ=1, ACTIVE_ID=0, STATUS=0x10; THRESHOLD=5 -> nIRQ=0.
